product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of multiplier_node.
- Consumes its 2N-bit unsigned product S, one accepted product per valid/ready beat.
- Sums TERMS consecutive products, then presents the registered total with a valid/ready handshake.
- Purpose: dot-product and MAC-style lab datapaths built around the multiplier node.

Parameters:
N, 4, operand width of the upstream multiplier_node; product width is 2N.
TERMS, 4, number of products summed per result (≥1).
ACC_W, 10, accumulator/result width (≥2N); default 2N+clog2(TERMS) makes overflow impossible.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort, discards partial sum.
prod  input  2N  product from multiplier_node S.
in_valid  input  1  prod is valid this cycle.
in_ready  output  1  block accepts prod this cycle.
sum  output  ACC_W  accumulated result, registered.
ovf  output  1  result saturated.
out_valid  output  1  sum/ovf valid.
out_ready  input  1  downstream accepts sum.
count  output  clog2(TERMS+1)  products accepted in current group.

Behaviour:
- Single clock domain (clk). Reset asynchronous, active-low (rst_n).
- Reset (rst_n=0, any time, including mid-group or in DONE):
  - state IDLE; acc, sum, count, ovf, out_valid all 0.
  - in_ready=1 one cycle after release.
- FSM states: IDLE, ACCUM, DONE.
- Beat: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- in_ready = 1 in IDLE/ACCUM, 0 in DONE; combinational from state only. out_valid = (state==DONE), registered.
- IDLE:
  - On beat: acc ← zero-extended prod; count ← 1; ovf ← 0.
  - Next state: DONE if TERMS==1, else ACCUM.
- ACCUM:
  - On beat: acc ← acc+prod computed in ACC_W+1 bits; count ← count+1.
  - If count+1==TERMS, go DONE.
  - No beat: hold all state. Gaps in in_valid are legal and unbounded.
- Overflow:
  - If the ACC_W+1 sum has its MSB set, acc ← all ones and ovf ← 1.
  - ovf is sticky for the rest of the group; acc stays saturated for later beats.
- DONE:
  - sum = acc; in_valid ignored; sum/ovf/count held stable while out_ready=0.
  - On transfer: next state IDLE; acc, count, ovf cleared.
  - One bubble cycle before the next group's first beat.
- Latency: last beat at edge k → out_valid=1 from edge k.
- Throughput: one result per TERMS+1 cycles at best.
- clear:
  - Highest priority below rst_n, acts in any state.
  - Next state IDLE; acc/count/ovf/out_valid ← 0; the beat in that cycle is discarded.
  - clear in DONE drops the pending result even when out_ready=1 the same cycle.
- sum is 0 whenever out_valid=0 (no stale partial sums visible).
- Unsigned arithmetic only; prod is treated as unsigned 2N bits.

Test Plan:
- N=4, TERMS=4, ACC_W=10: four beats of prod=66 (11×6), out_ready=1 → out_valid one cycle after 4th beat, sum=264, ovf=0, count=4, then IDLE with in_ready=1.
- Same config, four beats of prod=225 with random 0–3 cycle gaps on in_valid → sum=900, ovf=0; count steps 1,2,3,4 only on beats.
- ACC_W=9 instance: four beats of prod=225 → sum=511, ovf=1, saturation from 3rd beat.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 and prod=7 → in_ready=0; sum/ovf/count unchanged; no beat counted; transfer on 6th cycle.
- Two beats (prod=50), then clear=1 with in_valid=1 → count=0, no output; then four beats of prod=1 → sum=4.
- rst_n low asynchronously (between edges) after 3 beats → outputs 0 immediately; after release, four beats of prod=2 → sum=8.

Source files
------------

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums TERMS consecutive unsigned products and hands off the total over valid/ready
module product_accumulator #(
    parameter int N     = 4,
    parameter int TERMS = 4,
    parameter int ACC_W = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic [2*N-1:0]                 prod,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ACC_W-1:0]               sum,
    output logic                           ovf,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(TERMS+1)-1:0]     count
);

    localparam int CW = $clog2(TERMS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CW-1:0]    count_r, count_next, count_inc;
    logic             ovf_r, ovf_next;
    logic             out_valid_r;
    logic             beat;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   add_full;
    logic             last_term;

    assign in_ready  = (state != DONE);
    assign beat      = in_valid & in_ready;

    // The first beat of a group starts from zero so no explicit acc clear is needed on entry.
    assign base      = (state == IDLE) ? '0 : acc;
    assign add_full  = {1'b0, base} + (ACC_W + 1)'(prod);
    assign count_inc = (state == IDLE) ? CW'(1) : count_r + CW'(1);
    assign last_term = (count_inc == CW'(TERMS));

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count_r;
        ovf_next   = ovf_r;
        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        acc_next   = add_full[ACC_W-1:0];
                        count_next = count_inc;
                        ovf_next   = 1'b0;
                        state_next = last_term ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        // Once saturated, stay pinned at all ones for the rest of the group.
                        if (add_full[ACC_W] || ovf_r) begin
                            acc_next = '1;
                            ovf_next = 1'b1;
                        end else begin
                            acc_next = add_full[ACC_W-1:0];
                        end
                        count_next = count_inc;
                        if (last_term) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        count_next = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count_r     <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            count_r     <= count_next;
            ovf_r       <= ovf_next;
            out_valid_r <= (state_next == DONE);
        end
    end

    // Partial sums are never exposed; sum reads zero outside DONE.
    assign sum       = out_valid_r ? acc : '0;
    assign ovf       = ovf_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator (ACC_W=10 and ACC_W=9 instances)
module tb_product_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] prod;
    logic       a_in_valid, b_in_valid;
    logic       out_ready;

    logic       a_in_ready, a_ovf, a_out_valid;
    logic [9:0] a_sum;
    logic [2:0] a_count;
    logic       b_in_ready, b_ovf, b_out_valid;
    logic [8:0] b_sum;
    logic [2:0] b_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] sum;
        logic       ovf;
        logic [2:0] count;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    product_accumulator #(.N(4), .TERMS(4), .ACC_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod(prod),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .sum(a_sum), .ovf(a_ovf),
        .out_valid(a_out_valid), .out_ready(out_ready), .count(a_count)
    );

    product_accumulator #(.N(4), .TERMS(4), .ACC_W(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod(prod),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .sum(b_sum), .ovf(b_ovf),
        .out_valid(b_out_valid), .out_ready(out_ready), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [9:0] s, input logic o);
        exp_t e;
        e.sum = s; e.ovf = o; e.count = 3'd4;
        q_a.push_back(e);
    endtask

    // Presents one product and returns 1ns after the edge where it was accepted.
    task automatic beat(input bit sel_b, input logic [7:0] p);
        logic rdy;
        int   n;
        n = 0;
        prod = p;
        if (sel_b) b_in_valid = 1'b1; else a_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = sel_b ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 20) begin
                chk("beat_timeout", 32'd0, 32'd1);
                break;
            end
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    // Monitor: every output transfer is checked against the head of the matching queue.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && out_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_output", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                chk("a_sum", 32'(a_sum), 32'(ea.sum));
                chk("a_ovf", 32'(a_ovf), 32'(ea.ovf));
                chk("a_count", 32'(a_count), 32'(ea.count));
            end
        end
        if (rst_n && b_out_valid && out_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_output", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                chk("b_sum", 32'(b_sum), 32'(eb.sum));
                chk("b_ovf", 32'(b_ovf), 32'(eb.ovf));
                chk("b_count", 32'(b_count), 32'(eb.count));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=expired required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps[4];
        exp_t e;
        gaps = '{2, 0, 3, 1};

        rst_n = 1'b0; clear = 1'b0; prod = '0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_sum", 32'(a_sum), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);

        // Group 1: 4 x 66 back to back
        push_a(10'd264, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 8'd66);
        chk("g1_latency_out_valid", 32'(a_out_valid), 32'd1);
        chk("g1_sum_direct", 32'(a_sum), 32'd264);
        @(posedge clk); #1;
        chk("g1_idle_in_ready", 32'(a_in_ready), 32'd1);
        chk("g1_idle_out_valid", 32'(a_out_valid), 32'd0);
        chk("g1_idle_sum_zero", 32'(a_sum), 32'd0);

        // Group 2: 4 x 225 with gaps; count moves only on beats
        push_a(10'd900, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, 8'd225);
            chk("g2_count_step", 32'(a_count), 32'(i + 1));
            if (i < 3) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    @(posedge clk); #1;
                    chk("g2_count_hold", 32'(a_count), 32'(i + 1));
                    chk("g2_partial_sum_hidden", 32'(a_sum), 32'd0);
                end
            end
        end
        @(posedge clk); #1;

        // Group 3: ACC_W=9 instance saturates on the third beat
        e.sum = 10'd511; e.ovf = 1'b1; e.count = 3'd4;
        q_b.push_back(e);
        beat(1'b1, 8'd225);
        beat(1'b1, 8'd225);
        chk("g3_ovf_before", 32'(b_ovf), 32'd0);
        beat(1'b1, 8'd225);
        chk("g3_ovf_third", 32'(b_ovf), 32'd1);
        beat(1'b1, 8'd225);
        chk("g3_out_valid", 32'(b_out_valid), 32'd1);
        @(posedge clk); #1;

        // Group 4: back-pressure in DONE with in_valid asserted
        out_ready = 1'b0;
        push_a(10'd40, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 8'd10);
        a_in_valid = 1'b1; prod = 8'd7;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("g4_hold_in_ready", 32'(a_in_ready), 32'd0);
            chk("g4_hold_out_valid", 32'(a_out_valid), 32'd1);
            chk("g4_hold_sum", 32'(a_sum), 32'd40);
            chk("g4_hold_count", 32'(a_count), 32'd4);
            chk("g4_hold_ovf", 32'(a_ovf), 32'd0);
        end
        a_in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("g4_after_xfer_out_valid", 32'(a_out_valid), 32'd0);
        chk("g4_after_xfer_count", 32'(a_count), 32'd0);

        // Group 5: clear aborts a partial group, beat in that cycle is dropped
        beat(1'b0, 8'd50);
        beat(1'b0, 8'd50);
        chk("g5_pre_clear_count", 32'(a_count), 32'd2);
        a_in_valid = 1'b1; prod = 8'd50; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; a_in_valid = 1'b0;
        chk("g5_clear_count", 32'(a_count), 32'd0);
        chk("g5_clear_out_valid", 32'(a_out_valid), 32'd0);
        chk("g5_clear_in_ready", 32'(a_in_ready), 32'd1);
        push_a(10'd4, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 8'd1);
        @(posedge clk); #1;

        // Group 6: asynchronous reset mid-group
        for (int i = 0; i < 3; i++) beat(1'b0, 8'd9);
        chk("g6_pre_reset_count", 32'(a_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("g6_async_count", 32'(a_count), 32'd0);
        chk("g6_async_out_valid", 32'(a_out_valid), 32'd0);
        chk("g6_async_sum", 32'(a_sum), 32'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("g6_release_in_ready", 32'(a_in_ready), 32'd1);
        push_a(10'd8, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 8'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
